// File: rtl/reprodutor_musica_pkg.sv
// Shared definitions for the music player and the recording control unit.
//   estado_t   : FSM state encodings (also exported on db_estado)
//   TEMPO_FIM  : duration value that marks the end of a stored song
//   NOTA_PAUSA : note value that means "rest" (buzzer stays off)
package reprodutor_musica_pkg;

    typedef enum logic [2:0] {
        OCIOSO    = 3'd0,
        BUSCA     = 3'd1,
        CARREGA   = 3'd2,
        TOCA      = 3'd3,
        INTERVALO = 3'd4,
        FIM       = 3'd5
    } estado_t;

    localparam logic [3:0] TEMPO_FIM  = 4'd0;
    localparam logic [3:0] NOTA_PAUSA = 4'd0;

endpackage

// File: rtl/contador_m.sv
// Modulo-M counter used as a cycle timer.
//   clock : system clock, rising edge
//   reset : asynchronous active-low reset
//   zera  : synchronous clear, has priority over conta
//   conta : count enable
//   fim   : high on the enabled cycle in which the count wraps from M-1 to 0
module contador_m #(
    parameter int M = 10
) (
    input  logic clock,
    input  logic reset,
    input  logic zera,
    input  logic conta,
    output logic fim
);

    localparam int N = (M > 1) ? $clog2(M) : 1;
    localparam logic [N-1:0] ULTIMO = N'(M - 1);

    logic [N-1:0] q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (zera) begin
            q <= '0;
        end else if (conta) begin
            q <= (q == ULTIMO) ? '0 : q + N'(1);
        end
    end

    assign fim = conta && (q == ULTIMO);

endmodule

// File: rtl/reprodutor_musica.sv
// Music playback controller: walks the music RAM, plays each note for its
// duration in metronome beats, inserts a silent gap between notes.
//   clock, reset             : system clock / async active-low reset
//   inicia, para, pausa      : start pulse, abort, pause level
//   pulso_tempo              : one-cycle beat tick
//   mem_nota/tempo/fim       : RAM read data (one cycle after mem_addr)
//   mem_addr                 : RAM read address
//   nota, toca               : current note and buzzer enable (registered)
//   tocando, fim, db_estado  : busy, end-of-song pulse, state for debug
//
// state     | meaning
// OCIOSO    | idle, waiting for inicia
// BUSCA     | RAM read in flight for mem_addr
// CARREGA   | RAM data valid: latch note/duration or detect end of song
// TOCA      | note sounding, counting beats
// INTERVALO | silent gap between notes
// FIM       | one-cycle end-of-playback pulse
module reprodutor_musica
    import reprodutor_musica_pkg::*;
#(
    parameter int NUM_NOTAS  = 256,
    parameter int GAP_CYCLES = 1000
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         inicia,
    input  logic                         para,
    input  logic                         pausa,
    input  logic                         pulso_tempo,
    input  logic [3:0]                   mem_nota,
    input  logic [3:0]                   mem_tempo,
    input  logic                         mem_fim,
    output logic [$clog2(NUM_NOTAS)-1:0] mem_addr,
    output logic [3:0]                   nota,
    output logic                         toca,
    output logic                         tocando,
    output logic                         fim,
    output logic [2:0]                   db_estado
);

    localparam int AW = $clog2(NUM_NOTAS);
    localparam logic [AW-1:0] ULTIMO = AW'(NUM_NOTAS - 1);

    estado_t       estado, estado_d;
    logic [AW-1:0] addr_d;
    logic [3:0]    nota_d, duracao, duracao_d, batida, batida_d;
    logic          toca_d, fim_d;
    logic          gap_zera, gap_conta, gap_fim;

    contador_m #(.M(GAP_CYCLES)) u_gap (
        .clock (clock),
        .reset (reset),
        .zera  (gap_zera),
        .conta (gap_conta),
        .fim   (gap_fim)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado   <= OCIOSO;
            mem_addr <= '0;
            nota     <= '0;
            duracao  <= '0;
            batida   <= '0;
            toca     <= 1'b0;
            fim      <= 1'b0;
        end else begin
            estado   <= estado_d;
            mem_addr <= addr_d;
            nota     <= nota_d;
            duracao  <= duracao_d;
            batida   <= batida_d;
            toca     <= toca_d;
            fim      <= fim_d;
        end
    end

    always_comb begin
        estado_d  = estado;
        addr_d    = mem_addr;
        nota_d    = nota;
        duracao_d = duracao;
        batida_d  = batida;
        gap_zera  = 1'b1;
        gap_conta = 1'b0;

        // para also blocks a simultaneous inicia while idle
        if (para && estado != OCIOSO) begin
            estado_d = OCIOSO;
        end else begin
            case (estado)
                OCIOSO: begin
                    if (inicia && !para) begin
                        addr_d   = '0;
                        estado_d = BUSCA;
                    end
                end
                BUSCA: begin
                    if (!pausa) estado_d = CARREGA;
                end
                CARREGA: begin
                    if (!pausa) begin
                        if (mem_fim || mem_tempo == TEMPO_FIM) begin
                            estado_d = FIM;
                        end else begin
                            nota_d    = mem_nota;
                            duracao_d = mem_tempo;
                            batida_d  = '0;
                            estado_d  = TOCA;
                        end
                    end
                end
                TOCA: begin
                    if (!pausa && pulso_tempo) begin
                        batida_d = batida + 4'd1;
                        if (batida + 4'd1 == duracao) estado_d = INTERVALO;
                    end
                end
                INTERVALO: begin
                    gap_zera  = 1'b0;
                    gap_conta = !pausa;
                    if (gap_fim) begin
                        // last RAM slot ends the song instead of wrapping
                        if (mem_addr == ULTIMO) begin
                            estado_d = FIM;
                        end else begin
                            addr_d   = mem_addr + AW'(1);
                            estado_d = BUSCA;
                        end
                    end
                end
                FIM:     estado_d = OCIOSO;
                default: estado_d = OCIOSO;
            endcase
        end

        // outputs are decoded from the next state so they leave the flops
        // aligned with the state register
        toca_d = (estado_d == TOCA) && (nota_d != NOTA_PAUSA) && !pausa;
        fim_d  = (estado_d == FIM);
    end

    assign tocando   = (estado != OCIOSO);
    assign db_estado = estado;

endmodule

// File: tb/tb_reprodutor_musica.sv
// Self-checking bench for reprodutor_musica: behavioural sync RAM, beat
// generator, scoreboard of expected notes popped when each TOCA period ends.
module tb_reprodutor_musica;
    import reprodutor_musica_pkg::*;

    localparam int NN      = 4;
    localparam int GAP     = 10;
    localparam int PERIODO = 50;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       inicia = 1'b0, para = 1'b0, pausa = 1'b0;
    logic       tick_auto = 1'b0, tick_manual = 1'b0;
    logic       pulso_tempo;
    logic [3:0] mem_nota = '0, mem_tempo = '0;
    logic       mem_fim = 1'b0;
    logic [1:0] mem_addr;
    logic [3:0] nota;
    logic       toca, tocando, fim;
    logic [2:0] db_estado;

    logic [8:0] ram [NN];
    bit         ticks_on = 1'b0;
    int         tick_cnt = 0;

    int n_checks = 0, n_err = 0, n_fim = 0, toca_fora = 0, f0;

    typedef struct {
        int nota;
        int toca;
        int batidas;
    } esp_t;
    esp_t exp_q[$];

    bit em_toca = 1'b0;
    int obs_nota, obs_toca, obs_beats;

    assign pulso_tempo = tick_auto | tick_manual;
    always #5 clock = ~clock;

    reprodutor_musica #(.NUM_NOTAS(NN), .GAP_CYCLES(GAP)) dut (
        .clock       (clock),
        .reset       (reset),
        .inicia      (inicia),
        .para        (para),
        .pausa       (pausa),
        .pulso_tempo (pulso_tempo),
        .mem_nota    (mem_nota),
        .mem_tempo   (mem_tempo),
        .mem_fim     (mem_fim),
        .mem_addr    (mem_addr),
        .nota        (nota),
        .toca        (toca),
        .tocando     (tocando),
        .fim         (fim),
        .db_estado   (db_estado)
    );

    // synchronous-read music RAM: {fim, nota, tempo}
    always @(posedge clock) {mem_fim, mem_nota, mem_tempo} <= ram[mem_addr];

    // free-running metronome, updated after the main stimulus settles
    always @(posedge clock) begin
        #2;
        if (ticks_on && tick_cnt >= PERIODO - 1) begin
            tick_auto = 1'b1;
            tick_cnt  = 0;
        end else begin
            tick_auto = 1'b0;
            if (ticks_on) tick_cnt++;
        end
    end

    task automatic verifica(input string tag, input int obs, input int esp);
        n_checks++;
        if (obs != esp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, esp);
        end
    endtask

    // monitor: measures each TOCA period and checks it against the scoreboard
    always @(negedge clock) begin
        if (db_estado == TOCA) begin
            if (!em_toca) begin
                em_toca   = 1'b1;
                obs_nota  = int'(nota);
                obs_toca  = int'(toca);
                obs_beats = 0;
            end
            if (pulso_tempo && !pausa) obs_beats++;
        end else if (em_toca) begin
            em_toca = 1'b0;
            if (exp_q.size() == 0) begin
                verifica("sb_nota_extra", obs_nota, -1);
            end else begin
                esp_t e;
                e = exp_q.pop_front();
                verifica("sb_nota", obs_nota, e.nota);
                verifica("sb_toca", obs_toca, e.toca);
                verifica("sb_batidas", obs_beats, e.batidas);
            end
        end
        if (toca && db_estado != TOCA) toca_fora++;
        if (fim) n_fim++;
    end

    task automatic passo();
        @(posedge clock);
        #1;
    endtask

    task automatic espera(input string tag, input estado_t e, input int limite);
        for (int i = 0; i < limite && db_estado != e; i++) passo();
        verifica(tag, int'(db_estado), int'(e));
    endtask

    task automatic pulso();
        tick_manual = 1'b1;
        passo();
        tick_manual = 1'b0;
    endtask

    task automatic dispara();
        inicia = 1'b1;
        passo();
        inicia = 1'b0;
    endtask

    function automatic logic [8:0] ent(input int n, input int t, input bit f);
        return {f, 4'(n), 4'(t)};
    endfunction

    task automatic programa(input logic [8:0] e0, input logic [8:0] e1,
                            input logic [8:0] e2, input logic [8:0] e3);
        ram[0] = e0;
        ram[1] = e1;
        ram[2] = e2;
        ram[3] = e3;
    endtask

    task automatic espera_nota(input int n, input int b);
        esp_t e;
        e.nota    = n;
        e.toca    = (n != 0) ? 1 : 0;
        e.batidas = b;
        exp_q.push_back(e);
    endtask

    initial begin
        programa(ent(0, 0, 0), ent(0, 0, 0), ent(0, 0, 0), ent(0, 0, 0));
        #2 reset = 1'b0;
        #1;
        verifica("rst_estado", int'(db_estado), int'(OCIOSO));
        verifica("rst_addr", int'(mem_addr), 0);
        verifica("rst_nota", int'(nota), 0);
        verifica("rst_toca", int'(toca), 0);
        verifica("rst_fim", int'(fim), 0);
        verifica("rst_tocando", int'(tocando), 0);
        passo();
        passo();
        reset = 1'b1;
        repeat (3) passo();

        // basic song: note, rest, note, end marker
        programa(ent(5, 2, 0), ent(0, 1, 0), ent(3, 1, 0), ent(9, 0, 0));
        espera_nota(5, 2);
        espera_nota(0, 1);
        espera_nota(3, 1);
        f0 = n_fim;
        ticks_on = 1'b1;
        dispara();
        verifica("t1_tocando", int'(tocando), 1);
        espera("t1_fim", OCIOSO, 2000);
        ticks_on = 1'b0;
        verifica("t1_pulsos_fim", n_fim - f0, 1);
        verifica("t1_addr", int'(mem_addr), 3);
        verifica("t1_fila", exp_q.size(), 0);

        // tick coincident with CARREGA is discarded
        programa(ent(5, 2, 0), ent(9, 0, 0), ent(0, 0, 0), ent(0, 0, 0));
        espera_nota(5, 2);
        f0 = n_fim;
        dispara();
        espera("t2_carrega", CARREGA, 10);
        pulso();
        verifica("t2_toca", int'(db_estado), int'(TOCA));
        repeat (5) passo();
        pulso();
        repeat (3) passo();
        verifica("t2_ainda_toca", int'(db_estado), int'(TOCA));
        pulso();
        verifica("t2_intervalo", int'(db_estado), int'(INTERVALO));
        espera("t2_fim", OCIOSO, 100);
        verifica("t2_pulsos_fim", n_fim - f0, 1);

        // para during the second note
        programa(ent(5, 2, 0), ent(7, 3, 0), ent(3, 1, 0), ent(0, 0, 0));
        espera_nota(5, 2);
        espera_nota(7, 0);
        f0 = n_fim;
        ticks_on = 1'b1;
        dispara();
        espera("t3_toca1", TOCA, 100);
        espera("t3_intervalo", INTERVALO, 500);
        espera("t3_toca2", TOCA, 100);
        ticks_on = 1'b0;
        verifica("t3_nota2", int'(nota), 7);
        para = 1'b1;
        passo();
        para = 1'b0;
        verifica("t3_ocioso", int'(db_estado), int'(OCIOSO));
        verifica("t3_toca", int'(toca), 0);
        verifica("t3_tocando", int'(tocando), 0);
        repeat (GAP * 3) passo();
        verifica("t3_sem_fim", n_fim - f0, 0);
        verifica("t3_fila", exp_q.size(), 0);

        // pausa freezes the beat count for ~200 cycles
        programa(ent(6, 4, 0), ent(0, 0, 0), ent(0, 0, 0), ent(0, 0, 0));
        espera_nota(6, 4);
        f0 = n_fim;
        dispara();
        espera("t4_toca", TOCA, 10);
        pulso();
        repeat (3) passo();
        pausa = 1'b1;
        passo();
        passo();
        verifica("t4_toca_pausa", int'(toca), 0);
        for (int k = 0; k < 3; k++) begin
            repeat (60) passo();
            pulso();
        end
        repeat (15) passo();
        verifica("t4_estado_pausa", int'(db_estado), int'(TOCA));
        verifica("t4_nota_pausa", int'(nota), 6);
        verifica("t4_toca_pausa2", int'(toca), 0);
        pausa = 1'b0;
        passo();
        passo();
        verifica("t4_toca_retoma", int'(toca), 1);
        pulso();
        repeat (3) passo();
        pulso();
        repeat (3) passo();
        verifica("t4_ainda_toca", int'(db_estado), int'(TOCA));
        pulso();
        verifica("t4_intervalo", int'(db_estado), int'(INTERVALO));
        espera("t4_fim", OCIOSO, 100);
        verifica("t4_pulsos_fim", n_fim - f0, 1);

        // full memory without end marker: stops at last address, no wrap
        programa(ent(1, 1, 0), ent(1, 1, 0), ent(1, 1, 0), ent(1, 1, 0));
        for (int k = 0; k < NN; k++) espera_nota(1, 1);
        f0 = n_fim;
        ticks_on = 1'b1;
        dispara();
        espera("t5_fim", OCIOSO, 3000);
        ticks_on = 1'b0;
        verifica("t5_pulsos_fim", n_fim - f0, 1);
        verifica("t5_addr", int'(mem_addr), 3);
        verifica("t5_fila", exp_q.size(), 0);
        repeat (100) passo();
        verifica("t5_parado", int'(db_estado), int'(OCIOSO));
        verifica("t5_addr_final", int'(mem_addr), 3);

        // inicia ignored while playing; async reset mid-TOCA
        programa(ent(8, 3, 0), ent(0, 0, 0), ent(0, 0, 0), ent(0, 0, 0));
        espera_nota(8, 0);
        f0 = n_fim;
        dispara();
        espera("t6_toca", TOCA, 10);
        inicia = 1'b1;
        passo();
        inicia = 1'b0;
        verifica("t6_inicia_ignorado", int'(db_estado), int'(TOCA));
        #2 reset = 1'b0;
        #1;
        verifica("t6_rst_toca", int'(toca), 0);
        verifica("t6_rst_nota", int'(nota), 0);
        verifica("t6_rst_tocando", int'(tocando), 0);
        verifica("t6_rst_estado", int'(db_estado), int'(OCIOSO));
        verifica("t6_rst_addr", int'(mem_addr), 0);
        verifica("t6_rst_fim", int'(fim), 0);
        passo();
        reset = 1'b1;
        repeat (5) passo();
        verifica("t6_sem_reinicio", int'(db_estado), int'(OCIOSO));
        verifica("t6_sem_fim", n_fim - f0, 0);
        verifica("t6_fila", exp_q.size(), 0);
        verifica("toca_fora_de_toca", toca_fora, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
